// File: rtl/distance_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : distance_arbiter_if
// Description : Request/response bundle between N_REQ requesters, the
//               distance arbiter and the result consumer.
//               slave  - arbiter side (takes requests, produces responses)
//               master - environment side (issues requests, consumes results)
// Signals     : req_valid/req_ready   per-requester handshake (N_REQ bits)
//               req_x1/y1/x2/y2       packed operands, requester i at [i*W +: W]
//               resp_valid/resp_ready result handshake
//               resp_data             distance result (W bits)
//               resp_id               index of the owning requester
// Revision    : 1.0 - initial release
// ============================================================================
interface distance_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 32
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_x1;
  logic [N_REQ*W-1:0] req_y1;
  logic [N_REQ*W-1:0] req_x2;
  logic [N_REQ*W-1:0] req_y2;
  logic               resp_valid;
  logic               resp_ready;
  logic [W-1:0]       resp_data;
  logic [IDW-1:0]     resp_id;

  modport slave (
    input  req_valid, req_x1, req_y1, req_x2, req_y2, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id
  );

  modport master (
    output req_valid, req_x1, req_y1, req_x2, req_y2, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id
  );
endinterface
`default_nettype wire

// File: rtl/distance_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : distance
// Description : Combinational Euclidean distance,
//               res = floor(sqrt(|x2-x1|^2 + |y2-y1|^2)) at W bits.
// Ports       : x1, y1, x2, y2  unsigned coordinates (W bits each)
//               res             integer distance (W bits)
// Revision    : 1.0 - initial release
// ============================================================================
module distance #(
  parameter int W = 32
) (
  input  logic [W-1:0] x1,
  input  logic [W-1:0] y1,
  input  logic [W-1:0] x2,
  input  logic [W-1:0] y2,
  output logic [W-1:0] res
);
  logic [W-1:0]   dx;
  logic [W-1:0]   dy;
  logic [2*W:0]   dx_ext;
  logic [2*W:0]   dy_ext;
  logic [2*W:0]   sq;
  logic [2*W+1:0] rad;
  logic [W+2:0]   rem;
  logic [W+2:0]   trial;
  logic [W-1:0]   root;

  always_comb begin
    dx     = (x2 >= x1) ? (x2 - x1) : (x1 - x2);
    dy     = (y2 >= y1) ? (y2 - y1) : (y1 - y2);
    dx_ext = {{(W+1){1'b0}}, dx};
    dy_ext = {{(W+1){1'b0}}, dy};
    sq     = dx_ext * dx_ext + dy_ext * dy_ext;
    rad    = {1'b0, sq};
    rem    = '0;
    trial  = '0;
    root   = '0;
    // Digit-by-digit integer square root, two radicand bits per step.
    // The remainder never exceeds 2*root, so W+1 bits survive each shift.
    // The partial root only reaches W+1 bits on the final step, whose
    // MSB is dropped to give the W-bit result.
    for (int i = W; i >= 0; i--) begin
      rem   = {rem[W:0], rad[2*i +: 2]};
      trial = {1'b0, root, 2'b01};
      if (rem >= trial) begin
        rem  = rem - trial;
        root = {root[W-2:0], 1'b1};
      end else begin
        root = {root[W-2:0], 1'b0};
      end
    end
    res = root;
  end
endmodule

// ============================================================================
// Module      : distance_arbiter
// Description : Shares one distance datapath among N_REQ requesters using a
//               round-robin grant and an IDLE -> CALC -> RESP sequence.
// Ports       : clk   clock, rising edge
//               rst   synchronous active-high reset
//               bus   distance_arbiter_if.slave request/response bundle
//               busy  high whenever the FSM is not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module distance_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  distance_arbiter_if.slave      bus,
  output logic                   busy
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDW:0] N_EXT = (IDW+1)'(N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   x1_q, x1_d;
  logic [W-1:0]   y1_q, y1_d;
  logic [W-1:0]   x2_q, x2_d;
  logic [W-1:0]   y2_q, y2_d;
  logic [W-1:0]   resp_data_q, resp_data_d;

  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic [IDW:0]   cand;
  logic [IDW:0]   nxt;
  logic [W-1:0]   dist_res;

  // Round-robin pick: scan from ptr downwards in priority so the candidate
  // nearest to ptr (modulo N_REQ) is the one left standing.
  always_comb begin
    gnt_found = |bus.req_valid;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= N_EXT) begin
        cand = cand - N_EXT;
      end
      if (bus.req_valid[cand[IDW-1:0]]) begin
        gnt_idx = cand[IDW-1:0];
      end
    end
    nxt = {1'b0, gnt_idx} + (IDW+1)'(1);
    if (nxt >= N_EXT) begin
      nxt = '0;
    end
  end

  // Single shared datapath, fed only from the captured operands.
  distance #(.W(W)) u_distance (
    .x1  (x1_q),
    .y1  (y1_q),
    .x2  (x2_q),
    .y2  (y2_q),
    .res (dist_res)
  );

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    id_d          = id_q;
    x1_d          = x1_q;
    y1_d          = y1_q;
    x2_d          = x2_q;
    y2_d          = y2_q;
    resp_data_d   = resp_data_q;
    bus.req_ready = '0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          // Suppressed during reset so no requester believes it was accepted.
          bus.req_ready[gnt_idx] = ~rst;
          id_d    = gnt_idx;
          x1_d    = bus.req_x1[int'(gnt_idx)*W +: W];
          y1_d    = bus.req_y1[int'(gnt_idx)*W +: W];
          x2_d    = bus.req_x2[int'(gnt_idx)*W +: W];
          y2_d    = bus.req_y2[int'(gnt_idx)*W +: W];
          ptr_d   = nxt[IDW-1:0];
          state_d = CALC;
        end
      end
      CALC: begin
        resp_data_d = dist_res;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      x2_q        <= '0;
      y2_q        <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      x2_q        <= x2_d;
      y2_q        <= y2_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_id    = id_q;
  assign busy           = (state_q != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_distance_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_distance_arbiter
// Description : Directed self-checking bench for distance_arbiter
//               (4 requesters, 32-bit coordinates).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_distance_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  distance_arbiter_if #(.N_REQ(4), .W(32)) bus ();

  distance_arbiter #(.N_REQ(4), .W(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge, outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [31:0] x1, input logic [31:0] y1,
                         input logic [31:0] x2, input logic [31:0] y2);
    bus.req_x1[i*32 +: 32] = x1;
    bus.req_y1[i*32 +: 32] = y1;
    bus.req_x2[i*32 +: 32] = x2;
    bus.req_y2[i*32 +: 32] = y2;
    bus.req_valid[i]       = 1'b1;
  endtask

  // Called just after a rising edge; returns at the falling edge of the grant cycle.
  task automatic wait_grant(input string tag, input logic [3:0] exp);
    int n = 0;
    smp();
    while (bus.req_ready == 4'b0 && n < 8) begin
      cyc();
      smp();
      n++;
    end
    check({tag, " grant"}, bus.req_ready, exp);
  endtask

  // Called just after a rising edge; returns at the falling edge of the first RESP cycle.
  task automatic wait_resp(input string tag, input logic [31:0] exp_data, input logic [1:0] exp_id);
    int n = 0;
    smp();
    while (!bus.resp_valid && n < 8) begin
      cyc();
      smp();
      n++;
    end
    check({tag, " resp_valid"}, bus.resp_valid, 1);
    check({tag, " resp_data"}, bus.resp_data, exp_data);
    check({tag, " resp_id"}, bus.resp_id, exp_id);
  endtask

  logic [31:0] cont_exp [4];
  int          fair_id;

  initial begin
    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.req_x1     = '0;
    bus.req_y1     = '0;
    bus.req_x2     = '0;
    bus.req_y2     = '0;
    bus.resp_ready = 1'b0;
    set_req(0, 0, 0, 3, 4);
    bus.req_valid  = '0;

    // Reset state (request pending on requester 1 must not be accepted).
    cyc();
    bus.req_valid[1] = 1'b1;
    smp();
    check("rst req_ready", bus.req_ready, 0);
    check("rst resp_valid", bus.resp_valid, 0);
    check("rst busy", busy, 0);
    check("rst resp_data", bus.resp_data, 0);
    check("rst resp_id", bus.resp_id, 0);
    cyc();
    bus.req_valid = '0;
    rst = 1'b0;

    // Single request: grant at T, result at T+2.
    set_req(0, 0, 0, 3, 4);
    bus.resp_ready = 1'b1;
    smp();
    check("single grant", bus.req_ready, 4'b0001);
    cyc();
    bus.req_valid = '0;
    smp();
    check("single T+1 resp_valid", bus.resp_valid, 0);
    check("single T+1 busy", busy, 1);
    cyc();
    smp();
    check("single T+2 resp_valid", bus.resp_valid, 1);
    check("single resp_data", bus.resp_data, 5);
    check("single resp_id", bus.resp_id, 0);
    cyc();
    smp();
    check("single drop resp_valid", bus.resp_valid, 0);
    check("single drop busy", busy, 0);

    // Backpressure on requester 2 while requester 0 waits.
    cyc();
    bus.resp_ready = 1'b0;
    set_req(2, 0, 0, 640, 480);
    smp();
    check("bp grant", bus.req_ready, 4'b0100);
    cyc();
    bus.req_valid = '0;
    set_req(0, 0, 0, 6, 8);
    smp();
    check("bp calc req_ready", bus.req_ready, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      smp();
      check("bp resp_valid", bus.resp_valid, 1);
      check("bp resp_data", bus.resp_data, 800);
      check("bp resp_id", bus.resp_id, 2);
      check("bp busy", busy, 1);
      check("bp req_ready", bus.req_ready, 0);
    end
    cyc();
    bus.resp_ready = 1'b1;
    smp();
    check("bp handshake resp_valid", bus.resp_valid, 1);
    check("bp handshake req_ready", bus.req_ready, 0);
    cyc();
    smp();
    check("bp waiter grant", bus.req_ready, 4'b0001);
    check("bp after resp_valid", bus.resp_valid, 0);
    cyc();
    bus.req_valid = '0;
    wait_resp("bp waiter", 10, 0);
    cyc();

    // Idle: nothing requested for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      smp();
      check("idle req_ready", bus.req_ready, 0);
      check("idle resp_valid", bus.resp_valid, 0);
      check("idle busy", busy, 0);
      cyc();
    end

    // Contention: all four valid straight out of reset.
    rst = 1'b1;
    set_req(0, 0, 0, 30, 40);
    set_req(1, 0, 0, 300, 400);
    set_req(2, 0, 0, 100, 100);
    set_req(3, 0, 0, 3, 4);
    cont_exp[0] = 50;
    cont_exp[1] = 500;
    cont_exp[2] = 141;
    cont_exp[3] = 5;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_grant("cont", 4'(1 << k));
      cyc();
      bus.req_valid[k] = 1'b0;
      wait_resp("cont", cont_exp[k], 2'(k));
      cyc();
    end

    // Fairness: requesters 1 and 3 held valid continuously.
    set_req(1, 4, 5, 1, 1);
    set_req(3, 5, 0, 0, 12);
    for (int r = 0; r < 4; r++) begin
      fair_id = (r % 2 == 0) ? 1 : 3;
      wait_grant("fair", 4'(1 << fair_id));
      cyc();
      wait_resp("fair", (fair_id == 1) ? 32'd5 : 32'd13, 2'(fair_id));
      cyc();
    end
    bus.req_valid = '0;

    // Reset while in CALC discards the request and clears ptr.
    set_req(1, 0, 0, 8, 15);
    smp();
    check("rstcalc grant", bus.req_ready, 4'b0010);
    cyc();
    bus.req_valid = '0;
    rst = 1'b1;
    smp();
    check("rstcalc rst req_ready", bus.req_ready, 0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp();
      check("rstcalc resp_valid", bus.resp_valid, 0);
      check("rstcalc busy", busy, 0);
      cyc();
    end
    // ptr back at 0 selects 1 over 3; a ptr left at 2 would select 3.
    set_req(1, 0, 0, 8, 15);
    set_req(3, 0, 0, 7, 24);
    smp();
    check("rstcalc regrant", bus.req_ready, 4'b0010);
    cyc();
    bus.req_valid = '0;
    wait_resp("rstcalc", 17, 1);
    cyc();
    smp();
    check("rstcalc final resp_valid", bus.resp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/distance_arbiter.md
DISTANCE_ARBITER -- requirements
Module: distance_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the distance datapath.
REQ-002 Parameter W, default 32, coordinate and result width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  N_REQ  per-requester request-valid.
REQ-006 req_ready  output  N_REQ  per-requester accept; one-hot or zero.
REQ-007 req_x1, req_y1, req_x2, req_y2  input  N_REQ*W each  packed operands; requester i occupies bits [i*W +: W].
REQ-008 resp_valid  output  1  result available.
REQ-009 resp_ready  input  1  consumer accepts result.
REQ-010 resp_data  output  W  distance result.
REQ-011 resp_id  output  clog2(N_REQ)  index of the requester that owns resp_data.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The block shall contain exactly one instance of the existing combinational distance module and share it among all requesters.
REQ-014 The FSM shall have the states IDLE, CALC and RESP.
REQ-015 In IDLE with any req_valid bit high, the block shall grant one requester by round-robin, assert its req_ready bit combinationally in that cycle, capture its four operands and index into registers, and move to CALC.
REQ-016 The round-robin search shall start at pointer ptr and wrap modulo N_REQ; on a grant to index g, ptr shall become (g+1) mod N_REQ.
REQ-017 With no req_valid bit high in IDLE, req_ready shall be all zero and ptr shall hold.
REQ-018 req_ready shall be zero in CALC and RESP; requests arriving then shall wait and are not lost as long as the requester holds req_valid.
REQ-019 A requester may drop req_valid before it is granted; no state is retained for it.
REQ-020 In CALC, the distance instance shall see the registered operands; its res output shall be registered into resp_data, and the FSM shall move to RESP.
REQ-021 In RESP, resp_valid shall be 1, and resp_data and resp_id shall hold stable until resp_ready is 1.
REQ-022 In RESP with resp_ready=1, the FSM shall move to IDLE, and resp_valid shall drop on the next cycle.
REQ-023 Latency shall be a grant in cycle T and resp_valid first high in cycle T+2.
REQ-024 Peak throughput shall be one request per 3 cycles, with no grant in the cycle of the RESP handshake.
REQ-025 resp_ready asserted while resp_valid=0 shall have no effect.
REQ-026 resp_data shall equal the distance module output: floor(sqrt(dx^2+dy^2)) with dx=|x2-x1| and dy=|y2-y1|, at W bits, with no further truncation by this block.

Reset
REQ-027 Reset shall set state=IDLE, ptr=0, resp_valid=0, resp_data=0, resp_id=0, busy=0 and req_ready=0 in the reset cycle.
REQ-028 Reset in CALC or RESP shall discard the in-flight request with no response issued; that requester must re-request.
REQ-029 Reset shall take priority over every other event in the same cycle.

Verification
REQ-030 Single request: requester 0 sends (0,0)-(3,4), resp_ready=1. Required: req_ready[0] at T, resp_valid at T+2, resp_data=5, resp_id=0.
REQ-031 Backpressure: requester 2 sends (0,0)-(640,480) with resp_ready=0 for 5 cycles. Required: resp_valid held, resp_data=800 and resp_id=2 stable, busy=1, no new grant during that time.
REQ-032 Contention: all four requesters valid from reset with operands (0,0)-(30,40), (300,400), (100,100) and (3,4). Required: grant order 0,1,2,3 and results 50, 500, 141, 5.
REQ-033 Fairness: requesters 1 and 3 held valid continuously after a grant to 3. Required: grants alternate 1,3,1,3 and neither requester is starved.
REQ-034 Reset in CALC: requester 1 is granted and rst=1 the next cycle. Required: no resp_valid, ptr=0, and a later request from 1 is serviced normally.
REQ-035 Idle: all req_valid=0 for 10 cycles. Required: req_ready=0, resp_valid=0, busy=0 throughout.
